// File: rtl/ysyx_22040895_lsu_ctrl.sv
// Load/store controller: turns one EXU memory op into a single 64-bit bus beat with lane shifting,
// load extension and a request watchdog. Optional macro YSYX_22040895_MISALIGN_TRAP_EN adds misalign faults.
module ysyx_22040895_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i_lsc,
    input  logic        we_i_lsc,
    input  logic [1:0]  size_i_lsc,
    input  logic        uns_i_lsc,
    input  logic [63:0] addr_i_lsc,
    input  logic [63:0] wdata_i_lsc,
    output logic        stall_o_lsc,
    output logic        mem_valid_o_lsc,
    output logic        mem_we_o_lsc,
    output logic [63:0] mem_addr_o_lsc,
    output logic [63:0] mem_wdata_o_lsc,
    output logic [7:0]  mem_wmask_o_lsc,
    input  logic        mem_ready_i_lsc,
    input  logic [63:0] mem_rdata_i_lsc,
    output logic [63:0] rdata_o_lsc,
    output logic        done_o_lsc,
    output logic        timeout_o_lsc,
    output logic        fault_o_lsc
);

    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP
    } state_e;

    state_e              state_q, state_d;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [63:0]         addr_q;
    logic [63:0]         wdata_q;
    logic [63:0]         rdata_q, rdata_d;
    logic                timeout_q, timeout_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                capture;
    logic                trap_take;

    logic [7:0]          base_mask;
    logic [15:0]         wide_mask;
    logic [63:0]         rd_shifted;
    logic [63:0]         load_val;
    logic                sext;

`ifdef YSYX_22040895_MISALIGN_TRAP_EN
    logic misalign;
    logic fault_q;

    always_comb begin
        misalign = 1'b0;
        unique case (size_i_lsc)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr_i_lsc[0];
            2'b10:   misalign = |addr_i_lsc[1:0];
            default: misalign = |addr_i_lsc[2:0];
        endcase
    end

    assign trap_take = misalign;

    // Fault is only ever raised on the IDLE->RESP shortcut, so it is high exactly while done pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= (state_q == S_IDLE) && req_i_lsc && misalign;
        end
    end

    assign fault_o_lsc = fault_q;
`else
    assign trap_take   = 1'b0;
    assign fault_o_lsc = 1'b0;
`endif

    // Byte enables: bytes past lane 7 fall off the top of the 16-bit shift, truncating boundary crossers.
    always_comb begin
        base_mask = 8'h00;
        unique case (size_q)
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    assign wide_mask = {8'h00, base_mask} << addr_q[2:0];

    assign rd_shifted = mem_rdata_i_lsc >> {addr_q[2:0], 3'b000};
    assign sext       = ~uns_q;

    always_comb begin
        load_val = 64'h0;
        unique case (size_q)
            2'b00:   load_val = {{56{sext & rd_shifted[7]}},  rd_shifted[7:0]};
            2'b01:   load_val = {{48{sext & rd_shifted[15]}}, rd_shifted[15:0]};
            2'b10:   load_val = {{32{sext & rd_shifted[31]}}, rd_shifted[31:0]};
            default: load_val = rd_shifted;
        endcase
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        wdog_d    = wdog_q;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req_i_lsc) begin
                    capture   = 1'b1;
                    timeout_d = 1'b0;
                    wdog_d    = '0;
                    state_d   = trap_take ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ready_i_lsc) begin
                    state_d = S_RESP;
                    if (!we_q) begin
                        rdata_d = load_val;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            rdata_q   <= 64'h0;
            timeout_q <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
            wdog_q    <= wdog_d;
        end
    end

    // NOTE: the captured request fields are cleared on reset too, keeping the bus outputs defined from time zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 64'h0;
            wdata_q <= 64'h0;
        end else if (capture) begin
            we_q    <= we_i_lsc;
            size_q  <= size_i_lsc;
            uns_q   <= uns_i_lsc;
            addr_q  <= addr_i_lsc;
            wdata_q <= wdata_i_lsc;
        end
    end

    // Stall is gated by reset so the upstream pipeline is released the instant reset asserts.
    assign stall_o_lsc     = rst & (((state_q == S_IDLE) & req_i_lsc) | (state_q == S_REQ));
    assign mem_valid_o_lsc = (state_q == S_REQ);
    assign mem_we_o_lsc    = we_q;
    assign mem_addr_o_lsc  = {addr_q[63:3], 3'b000};
    assign mem_wdata_o_lsc = wdata_q << {addr_q[2:0], 3'b000};
    assign mem_wmask_o_lsc = wide_mask[7:0];
    assign rdata_o_lsc     = rdata_q;
    assign done_o_lsc      = (state_q == S_RESP);
    assign timeout_o_lsc   = timeout_q;

endmodule

// File: tb/tb_ysyx_22040895_lsu_ctrl.sv
// Scoreboard bench for ysyx_22040895_lsu_ctrl (watchdog shortened to 8 cycles).
module tb_ysyx_22040895_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i_lsc, we_i_lsc, uns_i_lsc;
    logic [1:0]  size_i_lsc;
    logic [63:0] addr_i_lsc, wdata_i_lsc;
    logic        stall_o_lsc, mem_valid_o_lsc, mem_we_o_lsc;
    logic [63:0] mem_addr_o_lsc, mem_wdata_o_lsc;
    logic [7:0]  mem_wmask_o_lsc;
    logic        mem_ready_i_lsc;
    logic [63:0] mem_rdata_i_lsc;
    logic [63:0] rdata_o_lsc;
    logic        done_o_lsc, timeout_o_lsc, fault_o_lsc;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  mask;
        logic [63:0] maddr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] last_load = 64'h0;

    ysyx_22040895_lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_i_lsc       (req_i_lsc),
        .we_i_lsc        (we_i_lsc),
        .size_i_lsc      (size_i_lsc),
        .uns_i_lsc       (uns_i_lsc),
        .addr_i_lsc      (addr_i_lsc),
        .wdata_i_lsc     (wdata_i_lsc),
        .stall_o_lsc     (stall_o_lsc),
        .mem_valid_o_lsc (mem_valid_o_lsc),
        .mem_we_o_lsc    (mem_we_o_lsc),
        .mem_addr_o_lsc  (mem_addr_o_lsc),
        .mem_wdata_o_lsc (mem_wdata_o_lsc),
        .mem_wmask_o_lsc (mem_wmask_o_lsc),
        .mem_ready_i_lsc (mem_ready_i_lsc),
        .mem_rdata_i_lsc (mem_rdata_i_lsc),
        .rdata_o_lsc     (rdata_o_lsc),
        .done_o_lsc      (done_o_lsc),
        .timeout_o_lsc   (timeout_o_lsc),
        .fault_o_lsc     (fault_o_lsc)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_mask(input logic [1:0] sz, input logic [2:0] off);
        logic [7:0] m = 8'h00;
        for (int i = 0; i < (1 << sz); i++)
            if (int'(off) + i < 8) m[int'(off) + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] off);
        logic [63:0] r = 64'h0;
        for (int i = 0; i < 8; i++)
            if (i >= int'(off)) r[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [2:0] off, input logic [63:0] bus);
        logic [63:0] r = 64'h0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++)
            if (int'(off) + i < 8) r[8*i +: 8] = bus[8*(int'(off) + i) +: 8];
        if (!uns && n < 8)
            for (int b = 8 * n; b < 64; b++) r[b] = r[8*n - 1];
        return r;
    endfunction

    task automatic run_txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] bus,
                           input int delay, input bit junk_req);
        exp_t e, g;
        int   lat;
        bit   seen;
        e.mask  = model_mask(sz, addr[2:0]);
        e.maddr = {addr[63:3], 3'b000};
        e.wdata = model_wdata(wd, addr[2:0]);
        e.rdata = we ? last_load : model_load(sz, uns, addr[2:0], bus);
        e.lat   = 2 + delay;
        sb.push_back(e);

        req_i_lsc = 1'b1; we_i_lsc = we; size_i_lsc = sz; uns_i_lsc = uns;
        addr_i_lsc = addr; wdata_i_lsc = wd;
        #1;
        n_vec++;
        if (stall_o_lsc !== 1'b1) begin
            n_err++; $display("FAIL %s stall_on_req: got %b want 1", tag, stall_o_lsc);
        end
        @(negedge clk);
        lat = 1;
        if (junk_req) begin
            addr_i_lsc = addr ^ 64'h40; wdata_i_lsc = ~wd; we_i_lsc = ~we;
        end else begin
            req_i_lsc = 1'b0;
        end
        for (int c = 0; c <= delay; c++) begin
            n_vec++;
            if (mem_valid_o_lsc !== 1'b1 || stall_o_lsc !== 1'b1 || done_o_lsc !== 1'b0 ||
                timeout_o_lsc !== 1'b0 || mem_we_o_lsc !== we) begin
                n_err++;
                $display("FAIL %s req_ctl c%0d: valid/stall/done/tmo/we got %b%b%b%b%b want 110%b%b",
                         tag, c, mem_valid_o_lsc, stall_o_lsc, done_o_lsc, timeout_o_lsc, mem_we_o_lsc, 1'b0, we);
            end
            n_vec++;
            if (mem_addr_o_lsc !== e.maddr || mem_wmask_o_lsc !== e.mask) begin
                n_err++;
                $display("FAIL %s req_addr_mask c%0d: got %h/%h want %h/%h",
                         tag, c, mem_addr_o_lsc, mem_wmask_o_lsc, e.maddr, e.mask);
            end
            if (we) begin
                n_vec++;
                if (mem_wdata_o_lsc !== e.wdata) begin
                    n_err++;
                    $display("FAIL %s req_wdata c%0d: got %h want %h", tag, c, mem_wdata_o_lsc, e.wdata);
                end
            end
            mem_ready_i_lsc = (c == delay);
            mem_rdata_i_lsc = (c == delay) ? bus : ~bus;
            @(negedge clk);
            lat++;
        end
        mem_ready_i_lsc = 1'b0;
        req_i_lsc = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (done_o_lsc === 1'b1) seen = 1'b1;
            else begin
                @(negedge clk); lat++;
            end
        end
        g = sb.pop_front();
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL %s done_missing: got none want pulse", tag);
        end else if (lat !== g.lat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, g.lat);
        end
        n_vec++;
        if (rdata_o_lsc !== g.rdata) begin
            n_err++; $display("FAIL %s rdata: got %h want %h", tag, rdata_o_lsc, g.rdata);
        end
        n_vec++;
        if (stall_o_lsc !== 1'b0 || mem_valid_o_lsc !== 1'b0 || fault_o_lsc !== 1'b0) begin
            n_err++;
            $display("FAIL %s resp_ctl: stall/valid/fault got %b%b%b want 000",
                     tag, stall_o_lsc, mem_valid_o_lsc, fault_o_lsc);
        end
        @(negedge clk);
        n_vec++;
        if (done_o_lsc !== 1'b0) begin
            n_err++; $display("FAIL %s done_pulse_width: got %b want 0", tag, done_o_lsc);
        end
        if (!we) last_load = g.rdata;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_i_lsc = 1'b1; we_i_lsc = 1'b0; size_i_lsc = 2'b00; uns_i_lsc = 1'b0;
        addr_i_lsc = 64'h0; wdata_i_lsc = 64'h0; mem_ready_i_lsc = 1'b0; mem_rdata_i_lsc = 64'h0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (stall_o_lsc !== 1'b0 || mem_valid_o_lsc !== 1'b0 || done_o_lsc !== 1'b0 ||
            timeout_o_lsc !== 1'b0 || fault_o_lsc !== 1'b0 || rdata_o_lsc !== 64'h0) begin
            n_err++;
            $display("FAIL reset_state: stall/valid/done/tmo/fault got %b%b%b%b%b rdata %h want 00000 0",
                     stall_o_lsc, mem_valid_o_lsc, done_o_lsc, timeout_o_lsc, fault_o_lsc, rdata_o_lsc);
        end
        req_i_lsc = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_store_dword();
        run_txn("sd", 1'b1, 2'b11, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 0, 1'b0);
    endtask

    task automatic test_load_byte();
        run_txn("lb", 1'b0, 2'b00, 1'b0, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 0, 1'b0);
        run_txn("lbu", 1'b0, 2'b00, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 0, 1'b0);
    endtask

    task automatic test_store_half_delayed();
        run_txn("sh_wait5", 1'b1, 2'b01, 1'b0, 64'h8000_0002, 64'h0000_0000_0000_ABCD, 64'h0, 5, 1'b1);
    endtask

    task automatic test_timeout();
        int  vcnt = 0;
        bit  done_seen = 1'b0;
        req_i_lsc = 1'b1; we_i_lsc = 1'b0; size_i_lsc = 2'b10; uns_i_lsc = 1'b0;
        addr_i_lsc = 64'h8000_0010; wdata_i_lsc = 64'h0;
        @(negedge clk);
        req_i_lsc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (mem_valid_o_lsc === 1'b1) vcnt++;
            if (done_o_lsc === 1'b1) done_seen = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (vcnt !== 8) begin
            n_err++; $display("FAIL timeout_valid_cycles: got %0d want 8", vcnt);
        end
        n_vec++;
        if (timeout_o_lsc !== 1'b1 || done_seen) begin
            n_err++; $display("FAIL timeout_flag: tmo got %b done_seen %b want 1 0", timeout_o_lsc, done_seen);
        end
        n_vec++;
        if (stall_o_lsc !== 1'b0) begin
            n_err++; $display("FAIL timeout_stall_release: got %b want 0", stall_o_lsc);
        end
        run_txn("after_timeout", 1'b0, 2'b10, 1'b0, 64'h8000_0014, 64'h0, 64'hDEAD_BEEF_0123_4567, 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        req_i_lsc = 1'b1; we_i_lsc = 1'b0; size_i_lsc = 2'b10; uns_i_lsc = 1'b0;
        addr_i_lsc = 64'h8000_0100; wdata_i_lsc = 64'h0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_vec++;
        if (mem_valid_o_lsc !== 1'b0 || stall_o_lsc !== 1'b0 || done_o_lsc !== 1'b0 ||
            timeout_o_lsc !== 1'b0 || rdata_o_lsc !== 64'h0) begin
            n_err++;
            $display("FAIL reset_mid: valid/stall/done/tmo got %b%b%b%b rdata %h want 0000 0",
                     mem_valid_o_lsc, stall_o_lsc, done_o_lsc, timeout_o_lsc, rdata_o_lsc);
        end
        last_load = 64'h0;
        @(negedge clk);
        req_i_lsc = 1'b0;
        rst = 1'b1;
        run_txn("lw_post_reset", 1'b0, 2'b10, 1'b0, 64'h8000_0104, 64'h0, 64'h8765_4321_0FED_CBA9, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 8; t++) begin
            logic [1:0]  sz   = 2'($urandom_range(0, 3));
            logic [2:0]  off  = 3'($urandom_range(0, 7));
            logic [63:0] addr = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FF8)};
            logic [63:0] wd   = {$urandom, $urandom};
            logic [63:0] bus  = {$urandom, $urandom};
            off  = off & ~(3'((1 << sz) - 1));
            addr = addr | {61'h0, off};
            run_txn($sformatf("b2b%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    addr, wd, bus, $urandom_range(0, 3), 1'b0);
        end
    endtask

    task automatic test_misalign();
`ifdef YSYX_22040895_MISALIGN_TRAP_EN
        logic [63:0] keep = last_load;
        req_i_lsc = 1'b1; we_i_lsc = 1'b0; size_i_lsc = 2'b10; uns_i_lsc = 1'b0;
        addr_i_lsc = 64'h8000_0002; wdata_i_lsc = 64'h0;
        @(negedge clk);
        req_i_lsc = 1'b0;
        n_vec++;
        if (mem_valid_o_lsc !== 1'b0 || fault_o_lsc !== 1'b1 || done_o_lsc !== 1'b1 || rdata_o_lsc !== keep) begin
            n_err++;
            $display("FAIL misalign_trap: valid/fault/done got %b%b%b rdata %h want 011 %h",
                     mem_valid_o_lsc, fault_o_lsc, done_o_lsc, rdata_o_lsc, keep);
        end
        @(negedge clk);
        n_vec++;
        if (fault_o_lsc !== 1'b0 || done_o_lsc !== 1'b0 || mem_valid_o_lsc !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_pulse: fault/done/valid got %b%b%b want 000",
                     fault_o_lsc, done_o_lsc, mem_valid_o_lsc);
        end
`else
        run_txn("lw_mis2", 1'b0, 2'b10, 1'b0, 64'h8000_0002, 64'h0, 64'hF0E1_D2C3_B4A5_9687, 0, 1'b0);
        run_txn("sd_cross4", 1'b1, 2'b11, 1'b0, 64'h8000_0004, 64'hCAFE_F00D_1234_5678, 64'h0, 1, 1'b0);
        run_txn("lh_cross7", 1'b0, 2'b01, 1'b0, 64'h8000_0007, 64'h0, 64'h9A00_0000_0000_0000, 0, 1'b0);
`endif
    endtask

    initial begin
        test_reset();
        test_store_dword();
        test_load_byte();
        test_store_half_delayed();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_misalign();
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
